// File: rtl/single_macc_decimator.sv
// Decimating 16-tap FIR: one multiplier walks the taps serially after each
// trigger, then rounds (floor) and saturates the Q1.17 result.
module single_macc_decimator #(
  parameter int DecimationK = 2
) (
  input  logic               Clk_i,
  input  logic               Rst_i,
  input  logic [3:0]         CoeffAddr_i,
  input  logic signed [17:0] CoeffData_i,
  input  logic               CoeffWr_i,
  input  logic signed [17:0] Data_i,
  input  logic               DataNd_i,
  output logic signed [17:0] Data_o,
  output logic               DataValid_o,
  output logic               Busy_o,
  output logic               Ovf_o
);

  localparam int DATA_W = 18;
  localparam int COEF_W = 18;
  localparam int TAPS   = 16;
  localparam int HIST   = 32;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = 40;
  localparam int FRAC   = 17;
  localparam int PH_W   = 4;
  localparam int SH_W   = ACC_W - FRAC;
  localparam logic [PH_W-1:0]        LAST_PH = PH_W'(DecimationK - 1);
  localparam logic signed [SH_W-1:0] MAX_V   = SH_W'(131071);
  localparam logic signed [SH_W-1:0] MIN_V   = -SH_W'(131072);

  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [DATA_W-1:0] hist [HIST];
  logic [4:0]      wr_ptr;
  logic [4:0]      base;
  logic [4:0]      rd_addr;
  logic [PH_W-1:0] phase;
  logic [3:0]      tap;
  logic            issue;
  logic            trig;
  logic            accept;

  logic                     vld_p0, first_p0, last_p0;
  logic signed [COEF_W-1:0] coef_p0;
  logic signed [DATA_W-1:0] x_p0;
  logic                     vld_p1, first_p1, last_p1;
  logic signed [PROD_W-1:0] prod_p1;
  logic                     done_p2;
  logic signed [ACC_W-1:0]  acc_p2;

  function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
    logic signed [SH_W-1:0] s;
    s = a[ACC_W-1:FRAC];
    if (s > MAX_V)      sat_out = 18'sh1FFFF;
    else if (s < MIN_V) sat_out = 18'sh20000;
    else                sat_out = s[DATA_W-1:0];
  endfunction

  // A trigger landing in the valid cycle starts a fresh computation.
  assign trig    = DataNd_i && (phase == LAST_PH);
  assign accept  = trig && (!Busy_o || DataValid_o);
  assign rd_addr = base - {1'b0, tap};

  always_ff @(posedge Clk_i) begin
    if (!Rst_i && CoeffWr_i) coef[CoeffAddr_i] <= CoeffData_i;
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      for (int i = 0; i < HIST; i++) hist[i] <= '0;
      wr_ptr <= '0;
      phase  <= '0;
    end else if (DataNd_i) begin
      hist[wr_ptr] <= Data_i;
      wr_ptr       <= wr_ptr + 5'd1;
      phase        <= (phase == LAST_PH) ? '0 : phase + 1'b1;
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      issue  <= 1'b0;
      tap    <= '0;
      base   <= '0;
      Busy_o <= 1'b0;
      Ovf_o  <= 1'b0;
    end else begin
      if (accept) begin
        issue  <= 1'b1;
        tap    <= '0;
        base   <= wr_ptr;
        Busy_o <= 1'b1;
      end else begin
        if (issue) begin
          tap <= tap + 4'd1;
          if (tap == 4'd15) issue <= 1'b0;
        end
        if (DataValid_o) Busy_o <= 1'b0;
      end
      if (trig && Busy_o && !DataValid_o) Ovf_o <= 1'b1;
    end
  end

  // p0: fetch coefficient and snapshot sample
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      last_p0  <= 1'b0;
      coef_p0  <= '0;
      x_p0     <= '0;
    end else begin
      vld_p0   <= issue;
      first_p0 <= issue && (tap == 4'd0);
      last_p0  <= issue && (tap == 4'd15);
      coef_p0  <= coef[tap];
      x_p0     <= hist[rd_addr];
    end
  end

  // p1: full-precision product
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      prod_p1  <= '0;
    end else begin
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      prod_p1  <= PROD_W'(coef_p0) * PROD_W'(x_p0);
    end
  end

  // p2: accumulate
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      done_p2 <= 1'b0;
      acc_p2  <= '0;
    end else begin
      done_p2 <= vld_p1 && last_p1;
      if (vld_p1) acc_p2 <= (first_p1 ? '0 : acc_p2) + ACC_W'(prod_p1);
    end
  end

  // output: shift, saturate and hold
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      Data_o      <= '0;
      DataValid_o <= 1'b0;
    end else begin
      DataValid_o <= done_p2;
      if (done_p2) Data_o <= sat_out(acc_p2);
    end
  end

endmodule

// File: tb/tb_single_macc_decimator.sv
// Directed bench for single_macc_decimator: impulse, DC, saturation,
// overflow, back-to-back triggers and reset abort with hand-computed outputs.
module tb_single_macc_decimator;

  logic        Clk_i = 1'b0;
  logic        Rst_i = 1'b1;
  logic [3:0]  CoeffAddr_i = '0;
  logic [17:0] CoeffData_i = '0;
  logic        CoeffWr_i = 1'b0;
  logic [17:0] Data_i = '0;
  logic        DataNd_i = 1'b0;
  logic [17:0] Data_o;
  logic        DataValid_o;
  logic        Busy_o;
  logic        Ovf_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_nd;
  logic [17:0] out_q [$];
  int          vc_q  [$];

  single_macc_decimator #(.DecimationK(2)) dut (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .CoeffAddr_i(CoeffAddr_i), .CoeffData_i(CoeffData_i),
    .CoeffWr_i(CoeffWr_i), .Data_i(Data_i), .DataNd_i(DataNd_i), .Data_o(Data_o),
    .DataValid_o(DataValid_o), .Busy_o(Busy_o), .Ovf_o(Ovf_o)
  );

  always #5 Clk_i = ~Clk_i;
  always @(posedge Clk_i) cyc <= cyc + 1;
  always @(negedge Clk_i) if (DataValid_o) begin
    out_q.push_back(Data_o);
    vc_q.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outv(input int i);
    outv = (i < out_q.size()) ? {14'b0, out_q[i]} : 32'hDEADBEEF;
  endfunction

  task automatic do_reset();
    Rst_i = 1'b1;
    repeat (2) @(negedge Clk_i);
    Rst_i = 1'b0;
  endtask

  task automatic wr_coef(input int k, input logic [17:0] v);
    CoeffAddr_i = 4'(k);
    CoeffData_i = v;
    CoeffWr_i   = 1'b1;
    @(negedge Clk_i);
    CoeffWr_i   = 1'b0;
  endtask

  task automatic coef_ramp();
    for (int k = 0; k < 16; k++) wr_coef(k, 18'((k + 1) * 256));
  endtask

  task automatic coef_const(input logic [17:0] v);
    for (int k = 0; k < 16; k++) wr_coef(k, v);
  endtask

  task automatic send(input logic [17:0] x, input int gap);
    Data_i   = x;
    DataNd_i = 1'b1;
    @(negedge Clk_i);
    DataNd_i = 1'b0;
    Data_i   = '0;
    last_nd  = cyc;
    repeat (gap - 1) @(negedge Clk_i);
  endtask

  initial begin
    int b, t;
    @(negedge Clk_i);
    @(negedge Clk_i);
    Rst_i = 1'b0;
    chk("rst_data", {14'b0, Data_o}, 32'h0);
    chk("rst_valid", {31'b0, DataValid_o}, 32'h0);
    chk("rst_busy", {31'b0, Busy_o}, 32'h0);
    chk("rst_ovf", {31'b0, Ovf_o}, 32'h0);

    // impulse on trigger phase
    coef_ramp();
    b = out_q.size();
    t = 0;
    for (int i = 0; i < 34; i++) begin
      send((i == 1) ? 18'h1FFFF : 18'h0, 24);
      if (i == 1) t = last_nd;
    end
    chk("imp_count", 32'(out_q.size() - b), 32'd17);
    chk("imp_latency", (vc_q.size() > b) ? 32'(vc_q[b] - t) : 32'hDEADBEEF, 32'd19);
    for (int j = 0; j < 17; j++)
      chk($sformatf("imp_out%0d", j), outv(b + j), (j < 8) ? 32'((2 * j + 1) * 256 - 1) : 32'h0);

    // cycle-accurate timing of a single computation
    b = out_q.size();
    send(18'h0, 1);
    send(18'h1FFFF, 1);
    t = last_nd;
    for (int k = 1; k <= 25; k++) begin
      @(negedge Clk_i);
      if (k == 1)  chk("tim_busy_start", {31'b0, Busy_o}, 32'h1);
      if (k == 18) chk("tim_valid_early", {31'b0, DataValid_o}, 32'h0);
      if (k == 19) chk("tim_valid", {31'b0, DataValid_o}, 32'h1);
      if (k == 19) chk("tim_busy_valid", {31'b0, Busy_o}, 32'h1);
      if (k == 20) chk("tim_valid_end", {31'b0, DataValid_o}, 32'h0);
      if (k == 20) chk("tim_busy_end", {31'b0, Busy_o}, 32'h0);
      if (k == 25) chk("tim_hold", {14'b0, Data_o}, 32'h0FF);
    end
    chk("tim_count", 32'(out_q.size() - b), 32'd1);

    // reset five cycles after a trigger aborts the computation
    do_reset();
    b = out_q.size();
    send(18'h0, 1);
    send(18'h1FFFF, 1);
    repeat (4) @(negedge Clk_i);
    Rst_i = 1'b1;
    @(negedge Clk_i);
    Rst_i = 1'b0;
    repeat (30) @(negedge Clk_i);
    chk("abort_count", 32'(out_q.size() - b), 32'd0);
    chk("abort_data", {14'b0, Data_o}, 32'h0);
    chk("abort_busy", {31'b0, Busy_o}, 32'h0);
    chk("abort_ovf", {31'b0, Ovf_o}, 32'h0);
    for (int i = 0; i < 10; i++) send((i == 1) ? 18'h1FFFF : 18'h0, 24);
    for (int j = 0; j < 5; j++)
      chk($sformatf("abort_imp%0d", j), outv(b + j), 32'((2 * j + 1) * 256 - 1));

    // impulse on non-trigger phase; coefficients survive reset
    do_reset();
    b = out_q.size();
    for (int i = 0; i < 32; i++) send((i == 0) ? 18'h1FFFF : 18'h0, 24);
    chk("odd_count", 32'(out_q.size() - b), 32'd16);
    for (int j = 0; j < 9; j++)
      chk($sformatf("odd_out%0d", j), outv(b + j), (j < 8) ? 32'((2 * j + 2) * 256 - 1) : 32'h0);

    // DC response
    do_reset();
    coef_const(18'h02000);
    b = out_q.size();
    for (int i = 0; i < 40; i++) send(18'h01000, 24);
    chk("dc_out0", outv(b), 32'h200);
    chk("dc_out7", outv(b + 7), 32'h1000);
    chk("dc_out19", outv(b + 19), 32'h1000);

    // saturation both ways
    do_reset();
    coef_const(18'h1FFFF);
    b = out_q.size();
    for (int i = 0; i < 4; i++) send(18'h1FFFF, 24);
    chk("sat_pos0", outv(b), 32'h1FFFF);
    chk("sat_pos1", outv(b + 1), 32'h1FFFF);
    do_reset();
    b = out_q.size();
    for (int i = 0; i < 4; i++) send(18'h20000, 24);
    chk("sat_neg0", outv(b), 32'h20000);
    chk("sat_neg1", outv(b + 1), 32'h20000);

    // overflow: sample every cycle
    do_reset();
    b = out_q.size();
    t = 0;
    for (int i = 0; i < 6; i++) begin
      Data_i   = 18'h00100;
      DataNd_i = 1'b1;
      @(negedge Clk_i);
      if (i == 1) t = cyc;
      if (i == 2) chk("ovf_before", {31'b0, Ovf_o}, 32'h0);
      if (i == 3) chk("ovf_set", {31'b0, Ovf_o}, 32'h1);
    end
    DataNd_i = 1'b0;
    Data_i   = '0;
    repeat (25) @(negedge Clk_i);
    chk("ovf_count", 32'(out_q.size() - b), 32'd1);
    chk("ovf_latency", (vc_q.size() > b) ? 32'(vc_q[b] - t) : 32'hDEADBEEF, 32'd19);
    chk("ovf_value", outv(b), 32'h1FF);
    chk("ovf_sticky", {31'b0, Ovf_o}, 32'h1);
    do_reset();
    chk("ovf_cleared", {31'b0, Ovf_o}, 32'h0);

    // trigger during the valid cycle is a new computation
    b = out_q.size();
    send(18'h00100, 1);
    send(18'h00100, 10);
    send(18'h00100, 10);
    send(18'h00100, 30);
    chk("b2b_ovf", {31'b0, Ovf_o}, 32'h0);
    chk("b2b_count", 32'(out_q.size() - b), 32'd2);
    chk("b2b_out0", outv(b), 32'h1FF);
    chk("b2b_out1", outv(b + 1), 32'h3FF);
    chk("b2b_gap", (vc_q.size() > b + 1) ? 32'(vc_q[b + 1] - vc_q[b]) : 32'hDEADBEEF, 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
